// File: rtl/div_sequencer_pkg.sv
// Shared multdiv definitions: default sizes, divider state encoding and the
// most-negative operand constant.
package div_sequencer_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift/subtract iteration over the {remainder, quotient} register.
module div_step
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH-1:0] work,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] work_next_c
);

  // Upper half after the shift, kept one bit wider so the carry-out is not lost.
  logic [WIDTH:0]   partial;
  logic             fits;
  logic [WIDTH-1:0] diff;

  assign partial = work[2*WIDTH-1:WIDTH-1];
  assign fits    = partial >= {1'b0, divisor};
  assign diff    = WIDTH'(partial - {1'b0, divisor});

  always_comb begin
    work_next_c = '0;
    work_next_c = {(fits ? diff : partial[WIDTH-1:0]), work[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_sequencer.sv
// Iterative signed divide controller: latches operands on ctrl_DIV, runs WIDTH
// restoring iterations, sign-corrects the quotient and pulses data_resultRDY.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] work;
  logic [2*WIDTH-1:0] work_next_c;
  logic [WIDTH-1:0]   divisor;
  logic               sign;

  logic [WIDTH-1:0]   a_abs_c;
  logic [WIDTH-1:0]   b_abs_c;
  logic               b_zero_c;
  logic               overflow_c;
  logic [WIDTH-1:0]   quotient_c;

  // Magnitudes; |INT_MIN| is representable because the datapath is unsigned.
  always_comb begin
    a_abs_c    = data_operandA[WIDTH-1] ? WIDTH'(-data_operandA) : data_operandA;
    b_abs_c    = data_operandB[WIDTH-1] ? WIDTH'(-data_operandB) : data_operandB;
    b_zero_c   = (data_operandB == '0);
    overflow_c = (data_operandA == MIN_NEG) && (&data_operandB);
    quotient_c = sign ? WIDTH'(-work[WIDTH-1:0]) : work[WIDTH-1:0];
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .work        (work),
    .divisor     (divisor),
    .work_next_c (work_next_c)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      work           <= '0;
      divisor        <= '0;
      sign           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_DIV) begin
            // Exception cases complete in a single edge without leaving IDLE.
            if (b_zero_c) begin
              data_result    <= '0;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
            end else if (overflow_c) begin
              data_result    <= MIN_NEG;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
            end else begin
              work    <= {{WIDTH{1'b0}}, a_abs_c};
              divisor <= b_abs_c;
              sign    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
              cnt     <= '0;
              state   <= RUN;
              busy    <= 1'b1;
            end
          end
        end
        RUN: begin
          work <= work_next_c;
          cnt  <= CNT_W'(cnt + 1'b1);
          if (cnt == LAST_STEP) begin
            state <= FIX;
          end
        end
        FIX: begin
          data_result    <= quotient_c;
          data_exception <= 1'b0;
          data_resultRDY <= 1'b1;
          state          <= IDLE;
          busy           <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a transaction-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  div_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signed quotient truncated toward zero, completion after 33 edges
  // (1 edge for divide-by-zero and INT_MIN / -1).
  int          edge_n  = 0;
  bit          started = 0;
  bit          pend    = 0;
  int          done_at = 0;
  logic [31:0] pend_res;
  logic [31:0] m_res   = '0;
  logic        m_exc   = 1'b0;
  logic        m_rdy   = 1'b0;
  logic        m_busy  = 1'b0;

  always @(posedge clock) begin
    edge_n++;
    m_rdy = 1'b0;
    if (!reset_n) begin
      started = 1;
      pend    = 0;
      m_res   = '0;
      m_exc   = 1'b0;
      m_busy  = 1'b0;
    end else if (pend && edge_n == done_at) begin
      pend   = 0;
      m_res  = pend_res;
      m_exc  = 1'b0;
      m_rdy  = 1'b1;
      m_busy = 1'b0;
    end else if (!pend && ctrl_DIV) begin
      if (data_operandB == 32'd0) begin
        m_res = 32'd0; m_exc = 1'b1; m_rdy = 1'b1;
      end else if (data_operandA == INT_MIN && data_operandB == 32'hFFFF_FFFF) begin
        m_res = INT_MIN; m_exc = 1'b1; m_rdy = 1'b1;
      end else begin
        pend_res = 32'($signed(data_operandA) / $signed(data_operandB));
        pend     = 1;
        done_at  = edge_n + 33;
        m_busy   = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the reference model.
  always @(negedge clock) begin
    if (started) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rdy", 32'(data_resultRDY), 32'(m_rdy));
      chk("result", data_result, m_res);
      chk("exception", 32'(data_exception), 32'(m_exc));
    end
  end

  // Issue one divide from the current negedge and wait for its completion.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_exc, input int exp_edge);
    int n;
    bit seen;
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    seen = 0;
    n    = 0;
    while (!seen && n < 40) begin
      @(negedge clock);
      ctrl_DIV = 1'b0;
      n++;
      if (data_resultRDY) seen = 1;
    end
    chk({name, "_done"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({name, "_edge"}, 32'(n - 1), 32'(exp_edge));
      chk({name, "_res"}, data_result, exp_res);
      chk({name, "_exc"}, 32'(data_exception), 32'(exp_exc));
    end
  endtask

  initial begin
    int n;
    bit seen;
    reset_n       = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    chk("reset_result", data_result, 32'd0);
    chk("reset_rdy", 32'(data_resultRDY), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    run_div("p28_3", 32'd28, 32'd3, 32'd9, 1'b0, 33);
    run_div("n28_3", 32'hFFFF_FFE4, 32'd3, 32'hFFFF_FFF7, 1'b0, 33);
    run_div("p28_n3", 32'd28, 32'hFFFF_FFFD, 32'hFFFF_FFF7, 1'b0, 33);
    run_div("n28_n3", 32'hFFFF_FFE4, 32'hFFFF_FFFD, 32'd9, 1'b0, 33);
    run_div("div0", 32'd7, 32'd0, 32'd0, 1'b1, 0);
    run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
    run_div("min_2", 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 33);

    // A second request while busy must be ignored.
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV      = 1'b1;
    seen = 0;
    n    = 0;
    while (!seen && n < 40) begin
      @(negedge clock);
      n++;
      ctrl_DIV = (n == 10);
      if (n == 10) begin
        data_operandA = 32'd50;
        data_operandB = 32'd5;
      end
      if (data_resultRDY) seen = 1;
    end
    chk("busy_ign_done", 32'(seen), 32'd1);
    chk("busy_ign_edge", 32'(n - 1), 32'd33);
    chk("busy_ign_res", data_result, 32'd14);
    // Issued in the ready cycle: accepted immediately.
    run_div("b2b", 32'd50, 32'd5, 32'd10, 1'b0, 33);

    // Reset mid-operation aborts with no completion.
    data_operandA = 32'd1000;
    data_operandB = 32'd10;
    ctrl_DIV      = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      ctrl_DIV = 1'b0;
    end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", data_result, 32'd0);
    chk("abort_exc", 32'(data_exception), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) seen = 1;
    end
    chk("abort_no_rdy", 32'(seen), 32'd0);
    run_div("p9_2", 32'd9, 32'd2, 32'd4, 1'b0, 33);

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
